eeg_wram_rd_arb: RTL and testbench

- Arbiter and sequencer for one single-port weight RAM (WRAM) bank, shared between one external write port (ETOW) and WBUF_NUM weight-buffer read requesters (PTOW).
- Sits between the per-bank WRAM macro and its WBUF group.
- Writes take priority. Reads are granted round-robin and flow-controlled by per-requester credits.
- Returned data per requester comes back in issue order through a 2-entry return FIFO.

---
 rtl/eeg_wram_rd_arb_if.sv | 38 +++
 rtl/eeg_wram_rd_arb.sv | 172 +++++++++++++++++
 tb/tb_eeg_wram_rd_arb.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeg_wram_rd_arb_if.sv
// Bus bundle for one WRAM bank arbiter: ETOW write port, PTOW read ports and the RAM macro pins.
// slave = arbiter side, master = the surrounding requesters plus RAM.
interface eeg_wram_rd_arb_if #(
  parameter int WBUF_NUM    = 4,
  parameter int WRAM_ADD_AW = 8,
  parameter int WRAM_DAT_DW = 32
);
  logic                            ETOW_DAT_VLD;
  logic                            ETOW_DAT_RDY;
  logic [WRAM_ADD_AW-1:0]          ETOW_DAT_ADD;
  logic [WRAM_DAT_DW-1:0]          ETOW_DAT_DAT;
  logic [WBUF_NUM-1:0]             PTOW_ADD_VLD;
  logic [WBUF_NUM-1:0]             PTOW_ADD_RDY;
  logic [WBUF_NUM*WRAM_ADD_AW-1:0] PTOW_ADD_ADD;
  logic [WBUF_NUM-1:0]             PTOW_DAT_VLD;
  logic [WBUF_NUM-1:0]             PTOW_DAT_RDY;
  logic [WBUF_NUM*WRAM_DAT_DW-1:0] PTOW_DAT_DAT;
  logic                            ram_cen;
  logic                            ram_wen;
  logic [WRAM_ADD_AW-1:0]          ram_add;
  logic [WRAM_DAT_DW-1:0]          ram_din;
  logic [WRAM_DAT_DW-1:0]          ram_dout;

  // Handshakes: a transfer happens on a clock edge where VLD and RDY are both 1.
  modport slave (
    input  ETOW_DAT_VLD, ETOW_DAT_ADD, ETOW_DAT_DAT,
    input  PTOW_ADD_VLD, PTOW_ADD_ADD, PTOW_DAT_RDY, ram_dout,
    output ETOW_DAT_RDY, PTOW_ADD_RDY, PTOW_DAT_VLD, PTOW_DAT_DAT,
    output ram_cen, ram_wen, ram_add, ram_din
  );

  modport master (
    output ETOW_DAT_VLD, ETOW_DAT_ADD, ETOW_DAT_DAT,
    output PTOW_ADD_VLD, PTOW_ADD_ADD, PTOW_DAT_RDY, ram_dout,
    input  ETOW_DAT_RDY, PTOW_ADD_RDY, PTOW_DAT_VLD, PTOW_DAT_DAT,
    input  ram_cen, ram_wen, ram_add, ram_din
  );
endinterface

// File: rtl/eeg_wram_rd_arb.sv
// WRAM bank arbiter: write-priority, round-robin credited reads, per-requester return FIFOs.
// Optional macro WRAM_ARB_FAIR_EN forces one read after 7 consecutive writes that blocked a read.
module eeg_wram_rd_arb #(
  parameter int WBUF_NUM    = 4,
  parameter int WRAM_ADD_AW = 8,
  parameter int WRAM_DAT_DW = 32,
  parameter int RBUF_DEPTH  = 2
) (
  input logic              clk,
  input logic              rst_n,
  eeg_wram_rd_arb_if.slave bus
);

  localparam int PW = (WBUF_NUM > 1) ? $clog2(WBUF_NUM) : 1;
  localparam int CW = $clog2(RBUF_DEPTH + 1);
  localparam int FW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          credit_q [WBUF_NUM];
  logic [CW-1:0]          credit_d [WBUF_NUM];
  logic [CW-1:0]          occ_q    [WBUF_NUM];
  logic [CW-1:0]          occ_d    [WBUF_NUM];
  logic [FW-1:0]          wp_q     [WBUF_NUM];
  logic [FW-1:0]          wp_d     [WBUF_NUM];
  logic [FW-1:0]          rp_q     [WBUF_NUM];
  logic [FW-1:0]          rp_d     [WBUF_NUM];
  logic [WRAM_DAT_DW-1:0] fifo_q   [WBUF_NUM][RBUF_DEPTH];

  logic                   ram_cen_q, ram_cen_d;
  logic                   ram_wen_q, ram_wen_d;
  logic [WRAM_ADD_AW-1:0] ram_add_q, ram_add_d;
  logic [WRAM_DAT_DW-1:0] ram_din_q, ram_din_d;
  logic                   tag1_vld_q, tag2_vld_q;
  logic [PW-1:0]          tag1_idx_q, tag2_idx_q;

  logic [WBUF_NUM-1:0]    elig, rd_gnt, push, pop, dat_vld;
  logic                   rd_found, wr_go, rd_go, fair_force;
  logic [PW-1:0]          rd_idx;

  function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
    return (p == FW'(RBUF_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    elig     = '0;
    rd_found = 1'b0;
    rd_idx   = '0;
    for (int i = 0; i < WBUF_NUM; i++) begin
      elig[i] = bus.PTOW_ADD_VLD[i] && (credit_q[i] < CW'(RBUF_DEPTH));
    end
    for (int k = 1; k <= WBUF_NUM; k++) begin
      if (!rd_found && elig[(int'(ptr_q) + k) % WBUF_NUM]) begin
        rd_found = 1'b1;
        rd_idx   = PW'((int'(ptr_q) + k) % WBUF_NUM);
      end
    end
  end

`ifdef WRAM_ARB_FAIR_EN
  logic [2:0] fair_cnt_q, fair_cnt_d;

  assign fair_force = (fair_cnt_q == 3'd7) && rd_found;

  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (rd_go || !rd_found) fair_cnt_d = 3'd0;
    else if (wr_go)         fair_cnt_d = fair_cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fair_cnt_q <= 3'd0;
    else        fair_cnt_q <= fair_cnt_d;
  end
`else
  assign fair_force = 1'b0;
`endif

  always_comb begin
    wr_go  = rst_n && bus.ETOW_DAT_VLD && !fair_force;
    rd_go  = rst_n && !wr_go && rd_found;
    rd_gnt = '0;
    if (rd_go) rd_gnt[rd_idx] = 1'b1;
    ptr_d     = rd_go ? rd_idx : ptr_q;
    ram_cen_d = wr_go || rd_go;
    ram_wen_d = wr_go;
    ram_add_d = ram_add_q;
    ram_din_d = ram_din_q;
    if (wr_go) begin
      ram_add_d = bus.ETOW_DAT_ADD;
      ram_din_d = bus.ETOW_DAT_DAT;
    end else if (rd_go) begin
      ram_add_d = bus.PTOW_ADD_ADD[int'(rd_idx)*WRAM_ADD_AW +: WRAM_ADD_AW];
    end
  end

  // Credits count FIFO occupancy plus reads still in the RAM pipeline.
  always_comb begin
    for (int i = 0; i < WBUF_NUM; i++) begin
      dat_vld[i]  = (occ_q[i] != '0);
      pop[i]      = dat_vld[i] && bus.PTOW_DAT_RDY[i];
      push[i]     = tag2_vld_q && (tag2_idx_q == PW'(i));
      credit_d[i] = credit_q[i];
      occ_d[i]    = occ_q[i];
      if (rd_gnt[i] && !pop[i])      credit_d[i] = credit_q[i] + CW'(1);
      else if (!rd_gnt[i] && pop[i]) credit_d[i] = credit_q[i] - CW'(1);
      if (push[i] && !pop[i])        occ_d[i] = occ_q[i] + CW'(1);
      else if (!push[i] && pop[i])   occ_d[i] = occ_q[i] - CW'(1);
      wp_d[i] = push[i] ? ptr_inc(wp_q[i]) : wp_q[i];
      rp_d[i] = pop[i]  ? ptr_inc(rp_q[i]) : rp_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= PW'(WBUF_NUM - 1);
      ram_cen_q  <= 1'b0;
      ram_wen_q  <= 1'b0;
      ram_add_q  <= '0;
      ram_din_q  <= '0;
      tag1_vld_q <= 1'b0;
      tag1_idx_q <= '0;
      tag2_vld_q <= 1'b0;
      tag2_idx_q <= '0;
      for (int i = 0; i < WBUF_NUM; i++) begin
        credit_q[i] <= '0;
        occ_q[i]    <= '0;
        wp_q[i]     <= '0;
        rp_q[i]     <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      ram_cen_q  <= ram_cen_d;
      ram_wen_q  <= ram_wen_d;
      ram_add_q  <= ram_add_d;
      ram_din_q  <= ram_din_d;
      tag1_vld_q <= rd_go;
      tag1_idx_q <= rd_idx;
      tag2_vld_q <= tag1_vld_q;
      tag2_idx_q <= tag1_idx_q;
      for (int i = 0; i < WBUF_NUM; i++) begin
        credit_q[i] <= credit_d[i];
        occ_q[i]    <= occ_d[i];
        wp_q[i]     <= wp_d[i];
        rp_q[i]     <= rp_d[i];
      end
    end
  end

  // Storage needs no reset: occupancy gates visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WBUF_NUM; i++) begin
      if (push[i]) fifo_q[i][wp_q[i]] <= bus.ram_dout;
    end
  end

  always_comb begin
    bus.PTOW_DAT_DAT = '0;
    for (int i = 0; i < WBUF_NUM; i++) begin
      bus.PTOW_DAT_DAT[i*WRAM_DAT_DW +: WRAM_DAT_DW] = fifo_q[i][rp_q[i]];
    end
  end

  assign bus.ETOW_DAT_RDY = wr_go;
  assign bus.PTOW_ADD_RDY = rd_gnt;
  assign bus.PTOW_DAT_VLD = dat_vld;
  assign bus.ram_cen      = ram_cen_q;
  assign bus.ram_wen      = ram_wen_q;
  assign bus.ram_add      = ram_add_q;
  assign bus.ram_din      = ram_din_q;

endmodule

// File: tb/tb_eeg_wram_rd_arb.sv
// Directed bench for eeg_wram_rd_arb with a behavioural single-port RAM and per-requester expected queues.
// Honours WRAM_ARB_FAIR_EN the same way as the design.
module tb_eeg_wram_rd_arb;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [DW-1:0] exp_q [N][$];
  logic [DW-1:0] ram_mem [256];
  int   rr_cnt [N];

  always #5 clk = ~clk;

  eeg_wram_rd_arb_if #(.WBUF_NUM(N), .WRAM_ADD_AW(AW), .WRAM_DAT_DW(DW)) bus ();

  eeg_wram_rd_arb #(.WBUF_NUM(N), .WRAM_ADD_AW(AW), .WRAM_DAT_DW(DW), .RBUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Single-port RAM macro: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (bus.ram_cen) begin
      if (bus.ram_wen) ram_mem[bus.ram_add] <= bus.ram_din;
      else             bus.ram_dout <= ram_mem[bus.ram_add];
    end
  end

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every consumed return word must match the front of its requester queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        if (bus.PTOW_DAT_VLD[i] && bus.PTOW_DAT_RDY[i]) begin
          if (exp_q[i].size() == 0)
            check_val($sformatf("unexpected_pop_r%0d", i), DW'(bus.PTOW_DAT_VLD[i]), '0);
          else
            check_val($sformatf("ret_data_r%0d", i), bus.PTOW_DAT_DAT[i*DW +: DW], exp_q[i].pop_front());
        end
      end
    end
  end

  task automatic set_rd(input int i, input logic v, input logic [AW-1:0] a);
    bus.PTOW_ADD_VLD[i] = v;
    bus.PTOW_ADD_ADD[i*AW +: AW] = a;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ETOW_DAT_VLD = 1'b1;
    bus.ETOW_DAT_ADD = a;
    bus.ETOW_DAT_DAT = d;
    @(negedge clk);
    check_val("wr_rdy", DW'(bus.ETOW_DAT_RDY), 1);
    tick();
    bus.ETOW_DAT_VLD = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ram_mem[a] = '0;
    rst_n            = 1'b0;
    bus.ETOW_DAT_VLD = 1'b1;
    bus.ETOW_DAT_ADD = '0;
    bus.ETOW_DAT_DAT = '0;
    bus.PTOW_ADD_VLD = '1;
    bus.PTOW_ADD_ADD = '0;
    bus.PTOW_DAT_RDY = '1;

    // Reset values, with requests asserted to show RDYs stay low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_etow_rdy", DW'(bus.ETOW_DAT_RDY), 0);
    check_val("rst_add_rdy",  DW'(bus.PTOW_ADD_RDY), 0);
    check_val("rst_dat_vld",  DW'(bus.PTOW_DAT_VLD), 0);
    check_val("rst_cen",      DW'(bus.ram_cen), 0);
    check_val("rst_wen",      DW'(bus.ram_wen), 0);
    check_val("rst_add",      DW'(bus.ram_add), 0);
    check_val("rst_din",      bus.ram_din, 0);
    bus.ETOW_DAT_VLD = 1'b0;
    bus.PTOW_ADD_VLD = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write 0x10, then requester 2 reads it back with 3-cycle latency.
    bus.ETOW_DAT_VLD = 1'b1;
    bus.ETOW_DAT_ADD = 8'h10;
    bus.ETOW_DAT_DAT = 32'hDEADBEEF;
    @(negedge clk);
    check_val("t1_wr_rdy",  DW'(bus.ETOW_DAT_RDY), 1);
    check_val("t1_add_rdy", DW'(bus.PTOW_ADD_RDY), 0);
    tick();
    bus.ETOW_DAT_VLD = 1'b0;
    set_rd(2, 1'b1, 8'h10);
    @(negedge clk);
    check_val("t1_wr_cen",  DW'(bus.ram_cen), 1);
    check_val("t1_wr_wen",  DW'(bus.ram_wen), 1);
    check_val("t1_wr_add",  DW'(bus.ram_add), 32'h10);
    check_val("t1_wr_din",  bus.ram_din, 32'hDEADBEEF);
    check_val("t1_rd_gnt",  DW'(bus.PTOW_ADD_RDY), 32'h4);
    exp_q[2].push_back(32'hDEADBEEF);
    tick();
    set_rd(2, 1'b0, 8'h00);
    @(negedge clk);
    check_val("t1_rd_cen",  DW'(bus.ram_cen), 1);
    check_val("t1_rd_wen",  DW'(bus.ram_wen), 0);
    check_val("t1_rd_add",  DW'(bus.ram_add), 32'h10);
    check_val("t1_vld_c1",  DW'(bus.PTOW_DAT_VLD), 0);
    tick();
    @(negedge clk);
    check_val("t1_idle_cen", DW'(bus.ram_cen), 0);
    check_val("t1_idle_add", DW'(bus.ram_add), 32'h10);
    check_val("t1_vld_c2",   DW'(bus.PTOW_DAT_VLD), 0);
    tick();
    @(negedge clk);
    check_val("t1_vld_c3", DW'(bus.PTOW_DAT_VLD), 32'h4);
    check_val("t1_dat_c3", bus.PTOW_DAT_DAT[2*DW +: DW], 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check_val("t1_vld_after_pop", DW'(bus.PTOW_DAT_VLD), 0);

    // Preload 0x30..0x37, then all four requesters stream; pointer last granted 2.
    for (int a = 8'h30; a < 8'h38; a++) do_write(AW'(a), 32'hA5000000 + DW'(a));
    for (int i = 0; i < N; i++) rr_cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      int e;
      for (int i = 0; i < N; i++)
        set_rd(i, rr_cnt[i] < 2, AW'(8'h30 + 4*rr_cnt[i] + i));
      e = (3 + c) % N;
      @(negedge clk);
      check_val($sformatf("t2_gnt_c%0d", c), DW'(bus.PTOW_ADD_RDY), DW'(1) << e);
      exp_q[e].push_back(32'hA5000000 + DW'(8'h30 + 4*rr_cnt[e] + e));
      rr_cnt[e]++;
      tick();
    end
    bus.PTOW_ADD_VLD = '0;
    repeat (6) tick();

    // Requester 1 with its return path stalled: credit limit of 2.
    do_write(8'h01, 32'h11);
    do_write(8'h02, 32'h22);
    do_write(8'h03, 32'h33);
    bus.PTOW_DAT_RDY[1] = 1'b0;
    set_rd(1, 1'b1, 8'h01);
    @(negedge clk);
    check_val("t3_gnt0", DW'(bus.PTOW_ADD_RDY), 32'h2);
    exp_q[1].push_back(32'h11);
    tick();
    set_rd(1, 1'b1, 8'h02);
    @(negedge clk);
    check_val("t3_gnt1", DW'(bus.PTOW_ADD_RDY), 32'h2);
    exp_q[1].push_back(32'h22);
    tick();
    set_rd(1, 1'b1, 8'h03);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val($sformatf("t3_blocked_c%0d", c), DW'(bus.PTOW_ADD_RDY), 0);
      tick();
    end
    @(negedge clk);
    check_val("t3_head_vld", DW'(bus.PTOW_DAT_VLD[1]), 1);
    check_val("t3_head_dat", bus.PTOW_DAT_DAT[1*DW +: DW], 32'h11);
    bus.PTOW_DAT_RDY[1] = 1'b1;
    #1;
    check_val("t3_pop_cycle_gnt", DW'(bus.PTOW_ADD_RDY), 0);
    tick();
    bus.PTOW_DAT_RDY[1] = 1'b0;
    @(negedge clk);
    check_val("t3_gnt2", DW'(bus.PTOW_ADD_RDY), 32'h2);
    exp_q[1].push_back(32'h33);
    tick();
    set_rd(1, 1'b0, 8'h00);
    repeat (4) tick();
    bus.PTOW_DAT_RDY[1] = 1'b1;
    repeat (4) tick();

    // Simultaneous write and read of 0x20: write first, read returns new data.
    bus.ETOW_DAT_VLD = 1'b1;
    bus.ETOW_DAT_ADD = 8'h20;
    bus.ETOW_DAT_DAT = 32'hCAFEF00D;
    set_rd(0, 1'b1, 8'h20);
    @(negedge clk);
    check_val("t4_wr_rdy",  DW'(bus.ETOW_DAT_RDY), 1);
    check_val("t4_rd_held", DW'(bus.PTOW_ADD_RDY), 0);
    tick();
    bus.ETOW_DAT_VLD = 1'b0;
    @(negedge clk);
    check_val("t4_wen",    DW'(bus.ram_wen), 1);
    check_val("t4_add",    DW'(bus.ram_add), 32'h20);
    check_val("t4_rd_gnt", DW'(bus.PTOW_ADD_RDY), 32'h1);
    exp_q[0].push_back(32'hCAFEF00D);
    tick();
    set_rd(0, 1'b0, 8'h00);
    repeat (5) tick();

    // Reset with two reads in flight; their data must never surface.
    set_rd(2, 1'b1, 8'h10);
    set_rd(3, 1'b1, 8'h20);
    @(negedge clk);
    check_val("t5_gnt_a", DW'(bus.PTOW_ADD_RDY), 32'h4);
    tick();
    set_rd(2, 1'b0, 8'h00);
    @(negedge clk);
    check_val("t5_gnt_b", DW'(bus.PTOW_ADD_RDY), 32'h8);
    tick();
    set_rd(3, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_vld", DW'(bus.PTOW_DAT_VLD), 0);
    check_val("t5_rst_cen", DW'(bus.ram_cen), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_rd(i, 1'b1, AW'(8'h30 + i));
    @(negedge clk);
    check_val("t5_first_gnt", DW'(bus.PTOW_ADD_RDY), 32'h1);
    exp_q[0].push_back(32'hA5000030);
    tick();
    bus.PTOW_ADD_VLD = '0;
    repeat (6) tick();

    // Continuous writes with requester 3 waiting.
    set_rd(3, 1'b1, 8'h50);
    for (int k = 0; k < 16; k++) begin
      logic exp_rd;
`ifdef WRAM_ARB_FAIR_EN
      exp_rd = (k % 8 == 7);
`else
      exp_rd = 1'b0;
`endif
      bus.ETOW_DAT_VLD = 1'b1;
      bus.ETOW_DAT_ADD = 8'h50;
      bus.ETOW_DAT_DAT = DW'(k);
      @(negedge clk);
      check_val($sformatf("t6_wr_rdy_k%0d", k), DW'(bus.ETOW_DAT_RDY), DW'(!exp_rd));
      check_val($sformatf("t6_rd_gnt_k%0d", k), DW'(bus.PTOW_ADD_RDY), exp_rd ? 32'h8 : 32'h0);
      if (exp_rd) exp_q[3].push_back(DW'(k - 1));
      tick();
    end
    bus.ETOW_DAT_VLD = 1'b0;
    set_rd(3, 1'b0, 8'h00);
    repeat (6) tick();

    for (int i = 0; i < N; i++)
      check_val($sformatf("leftover_r%0d", i), DW'(exp_q[i].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
